video_fetch_fifo: RTL and testbench

VIDEO_FETCH_FIFO -- requirements
Module: video_fetch_fifo

---
 rtl/video_fetch_fifo_pkg.sv | 20 ++
 rtl/video_fetch_fifo_if.sv | 25 ++
 rtl/sync_fifo_ram.sv | 53 +++++
 rtl/video_fetch_fifo.sv | 146 ++++++++++++++
 tb/tb_video_fetch_fifo.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/video_fetch_fifo_pkg.sv
// Shared constants and types for the video fetch FIFO: FSM encoding, default geometry
// and the byte-lane selector used by the display side.
package video_fetch_fifo_pkg;

  localparam int unsigned DefaultAddrWidth     = 30;
  localparam int unsigned DefaultFifoDepthLog2 = 4;
  localparam int unsigned DefaultFrameWords    = 9600;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  // Little-endian lane select: idx 0 is bits [7:0].
  function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/video_fetch_fifo_if.sv
// Memory fetch bus and display-stage byte port of the video fetch FIFO.
// master is the fetch engine side; slave is the memory/display environment.
interface video_fetch_fifo_if #(
  parameter int unsigned addr_width = video_fetch_fifo_pkg::DefaultAddrWidth
) ();

  logic [addr_width-1:0] mem_addr;
  logic                  mem_strobe;
  logic                  mem_ack;
  logic [31:0]           mem_data;
  logic                  rd;
  logic [7:0]            dispData;
  logic                  underrun;

  modport master (
    output mem_addr, mem_strobe, dispData, underrun,
    input  mem_ack, mem_data, rd
  );

  modport slave (
    input  mem_addr, mem_strobe, dispData, underrun,
    output mem_ack, mem_data, rd
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Word FIFO with separate read/write pointers and an occupancy count.
// Head word is read combinationally at the read pointer; flush clears pointers and count.
module sync_fifo_ram #(
  parameter int unsigned DepthLog2 = 4,
  parameter int unsigned Width     = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 pop_i,
  output logic [Width-1:0]     head_o,
  output logic [DepthLog2:0]   count_o
);

  localparam int unsigned Depth = 2 ** DepthLog2;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DepthLog2:0]   count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/video_fetch_fifo.sv
// Frame-buffer prefetch engine: fetches words from memory into a FIFO on each frame start
// and hands them to the display stage one byte per rd pulse.
module video_fetch_fifo
  import video_fetch_fifo_pkg::*;
#(
  parameter int unsigned addr_width      = DefaultAddrWidth,
  parameter int unsigned fifo_depth_log2 = DefaultFifoDepthLog2,
  parameter int unsigned frame_words     = DefaultFrameWords
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] base_addr,
  input  logic                  vga_vsync,
  video_fetch_fifo_if.master    bus
);

  localparam int unsigned CntW  = $clog2(frame_words + 1);
  localparam int unsigned Depth = 2 ** fifo_depth_log2;

  typedef logic [fifo_depth_log2:0] fcnt_t;

  logic vsync_q1, vsync_q2, vsync_q3;
  logic restart;

  fetch_state_e          state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [CntW-1:0]       word_cnt_q, word_cnt_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic                  underrun_q, underrun_d;

  logic        strobe_req, strobe, push, pop, flush, rd_ok, fifo_empty;
  logic [31:0] head;
  fcnt_t       count;

  // Synchronizer idles high (vsync inactive) so reset never fakes a frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q1 <= 1'b1;
      vsync_q2 <= 1'b1;
      vsync_q3 <= 1'b1;
    end else begin
      vsync_q1 <= vga_vsync;
      vsync_q2 <= vsync_q1;
      vsync_q3 <= vsync_q2;
    end
  end

  assign restart    = vsync_q3 & ~vsync_q2;
  assign fifo_empty = (count == '0);
  assign strobe_req = (count < fcnt_t'(Depth)) && (word_cnt_q < CntW'(frame_words));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    strobe     = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (restart) begin
          flush   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        strobe = strobe_req;
        if (restart) begin
          // A request still waiting for its ack must finish before the bus can be reused.
          if (strobe_req && !bus.mem_ack) state_d = StDrain;
          else                            flush   = 1'b1;
        end else if (strobe_req && bus.mem_ack) begin
          push       = 1'b1;
          addr_d     = addr_q + 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_d == CntW'(frame_words)) state_d = StIdle;
        end
      end
      StDrain: begin
        strobe = 1'b1;
        if (bus.mem_ack) begin
          flush   = 1'b1;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      addr_d     = base_addr;
      word_cnt_d = '0;
    end
  end

  always_comb begin
    byte_idx_d = byte_idx_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
    rd_ok      = bus.rd && !restart && !flush;
    if (rd_ok) begin
      if (fifo_empty) begin
        underrun_d = 1'b1;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
        pop        = (byte_idx_q == 2'd3);
      end
    end
    if (flush) byte_idx_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      underrun_q <= underrun_d;
    end
  end

  sync_fifo_ram #(
    .DepthLog2(fifo_depth_log2),
    .Width    (32)
  ) u_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .flush_i(flush),
    .push_i (push),
    .wdata_i(bus.mem_data),
    .pop_i  (pop),
    .head_o (head),
    .count_o(count)
  );

  // Strobe is gated by reset so a reset mid-handshake withdraws it immediately.
  assign bus.mem_addr   = addr_q;
  assign bus.mem_strobe = strobe & ~reset;
  assign bus.dispData   = fifo_empty ? 8'h00 : select_byte(head, byte_idx_q);
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_video_fetch_fifo.sv
// Directed bench for video_fetch_fifo: fill, byte order, frame limit, underrun,
// restart-while-pending drain, reset mid-handshake and address wrap.
module tb_video_fetch_fifo;

  localparam int unsigned AW = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] base_addr;
  logic          vga_vsync;

  video_fetch_fifo_if #(.addr_width(AW)) bus ();

  video_fetch_fifo #(
    .addr_width     (AW),
    .fifo_depth_log2(4),
    .frame_words    (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .base_addr(base_addr),
    .vga_vsync(vga_vsync),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  bit            ack_en = 1'b0;
  bit            seen   = 1'b0;
  logic [AW-1:0] req_q[$];

  function automatic logic [31:0] data_for(input logic [AW-1:0] a);
    return 32'h4433_2211 + {4{a[7:0]}};
  endfunction

  // One clock; memory answers one cycle after it first sees a strobe.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      seen        = 1'b0;
    end else if (ack_en && bus.mem_strobe) begin
      if (seen) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = data_for(bus.mem_addr);
        req_q.push_back(bus.mem_addr);
        seen = 1'b0;
      end else begin
        seen = 1'b1;
      end
    end else begin
      seen = 1'b0;
    end
  endtask

  task automatic vsync_pulse();
    vga_vsync = 1'b0;
    repeat (3) cycle();
    vga_vsync = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; vga_vsync = 1'b1; base_addr = '0;
    bus.rd = 1'b0; bus.mem_ack = 1'b0; bus.mem_data = '0;
    repeat (3) cycle();
    checks++; if (bus.mem_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", bus.mem_strobe); end
    checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", bus.underrun); end
    checks++; if (bus.dispData !== 8'h00) begin errors++; $display("FAIL reset_disp: got %h want 00", bus.dispData); end
    reset = 1'b0;
    repeat (2) cycle();
    checks++; if (bus.mem_strobe !== 1'b0) begin errors++; $display("FAIL idle_strobe: got %b want 0", bus.mem_strobe); end
  endtask

  task automatic test_fill();
    base_addr = AW'(32'h100);
    req_q.delete();
    ack_en = 1'b1;
    vsync_pulse();
    for (int i = 0; i < 100 && req_q.size() < 16; i++) cycle();
    repeat (6) cycle();
    checks++; if (req_q.size() !== 16) begin errors++; $display("FAIL fill_count: got %0d want 16", req_q.size()); end
    for (int i = 0; i < req_q.size(); i++) begin
      checks++;
      if (req_q[i] !== AW'(32'h100 + i)) begin
        errors++; $display("FAIL fill_addr[%0d]: got %h want %h", i, req_q[i], 32'h100 + i);
      end
    end
    checks++; if (bus.mem_strobe !== 1'b0) begin errors++; $display("FAIL fill_full_strobe: got %b want 0", bus.mem_strobe); end
    checks++; if (bus.dispData !== 8'h11) begin errors++; $display("FAIL fill_head: got %h want 11", bus.dispData); end
  endtask

  task automatic test_bytes();
    logic [7:0] exp [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h12};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.dispData !== exp[i]) begin
        errors++; $display("FAIL byte_order[%0d]: got %h want %h", i, bus.dispData, exp[i]);
      end
      if (i < 4) begin
        bus.rd = 1'b1; cycle(); bus.rd = 1'b0;
      end
    end
  endtask

  task automatic test_frame_limit();
    bus.rd = 1'b1;
    repeat (40) cycle();
    bus.rd = 1'b0;
    repeat (20) cycle();
    checks++; if (req_q.size() !== 20) begin errors++; $display("FAIL frame_acks: got %0d want 20", req_q.size()); end
    if (req_q.size() >= 20) begin
      checks++; if (req_q[19] !== AW'(32'h113)) begin errors++; $display("FAIL frame_last_addr: got %h want 113", req_q[19]); end
    end
    checks++; if (bus.mem_strobe !== 1'b0) begin errors++; $display("FAIL frame_idle_strobe: got %b want 0", bus.mem_strobe); end
    checks++; if (bus.dispData !== 8'h1C) begin errors++; $display("FAIL frame_head: got %h want 1c", bus.dispData); end
  endtask

  task automatic test_underrun();
    bus.rd = 1'b1;
    repeat (36) cycle();
    bus.rd = 1'b0;
    cycle();
    checks++; if (bus.dispData !== 8'h00) begin errors++; $display("FAIL empty_disp: got %h want 00", bus.dispData); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL no_underrun: got %b want 0", bus.underrun); end
    bus.rd = 1'b1;
    cycle();
    bus.rd = 1'b0;
    checks++; if (bus.underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got %b want 1", bus.underrun); end
    checks++; if (bus.dispData !== 8'h00) begin errors++; $display("FAIL underrun_disp: got %h want 00", bus.dispData); end
    cycle();
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL underrun_len: got %b want 0", bus.underrun); end
  endtask

  task automatic test_drain();
    base_addr = AW'(32'h100);
    req_q.delete();
    ack_en = 1'b1;
    vsync_pulse();
    for (int i = 0; i < 100 && req_q.size() < 5; i++) cycle();
    ack_en = 1'b0;
    cycle();
    vsync_pulse();
    checks++; if (bus.mem_strobe !== 1'b1) begin errors++; $display("FAIL drain_strobe: got %b want 1", bus.mem_strobe); end
    checks++; if (bus.mem_addr !== AW'(32'h105)) begin errors++; $display("FAIL drain_addr: got %h want 105", bus.mem_addr); end
    checks++; if (bus.dispData !== 8'h11) begin errors++; $display("FAIL drain_head: got %h want 11", bus.dispData); end
    bus.mem_ack = 1'b1; bus.mem_data = 32'hDEAD_BEEF;
    cycle();
    checks++; if (bus.mem_addr !== AW'(32'h100)) begin errors++; $display("FAIL restart_addr: got %h want 100", bus.mem_addr); end
    checks++; if (bus.mem_strobe !== 1'b1) begin errors++; $display("FAIL restart_strobe: got %b want 1", bus.mem_strobe); end
    checks++; if (bus.dispData !== 8'h00) begin errors++; $display("FAIL restart_flush: got %h want 00", bus.dispData); end
    req_q.delete();
    ack_en = 1'b1;
    for (int i = 0; i < 20 && req_q.size() < 1; i++) cycle();
    repeat (2) cycle();
    checks++; if (req_q.size() < 1) begin errors++; $display("FAIL restart_req: got %0d requests want >=1", req_q.size()); end
    else if (req_q[0] !== AW'(32'h100)) begin errors++; $display("FAIL restart_req: got %h want 100", req_q[0]); end
    checks++; if (bus.dispData !== 8'h11) begin errors++; $display("FAIL restart_head: got %h want 11", bus.dispData); end
  endtask

  task automatic test_reset_mid();
    ack_en = 1'b0;
    for (int i = 0; i < 10 && !(bus.mem_strobe && !bus.mem_ack); i++) cycle();
    reset = 1'b1;
    #1;
    checks++; if (bus.mem_strobe !== 1'b0) begin errors++; $display("FAIL rst_mid_strobe: got %b want 0", bus.mem_strobe); end
    cycle();
    reset = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_data = 32'h9999_9999;
    cycle();
    checks++; if (bus.mem_strobe !== 1'b0) begin errors++; $display("FAIL late_ack_strobe: got %b want 0", bus.mem_strobe); end
    checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL late_ack_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL late_ack_underrun: got %b want 0", bus.underrun); end
    checks++; if (bus.dispData !== 8'h00) begin errors++; $display("FAIL late_ack_disp: got %h want 00", bus.dispData); end
    repeat (3) cycle();
    checks++; if (bus.mem_strobe !== 1'b0) begin errors++; $display("FAIL post_rst_strobe: got %b want 0", bus.mem_strobe); end
  endtask

  task automatic test_wrap();
    base_addr = AW'(32'h3FFF_FFFF);
    req_q.delete();
    ack_en = 1'b1;
    vsync_pulse();
    for (int i = 0; i < 50 && req_q.size() < 2; i++) cycle();
    checks++; if (req_q.size() < 2) begin errors++; $display("FAIL wrap_reqs: got %0d want >=2", req_q.size()); end
    else begin
      checks++; if (req_q[0] !== AW'(32'h3FFF_FFFF)) begin errors++; $display("FAIL wrap_first: got %h want 3fffffff", req_q[0]); end
      checks++; if (req_q[1] !== '0) begin errors++; $display("FAIL wrap_next: got %h want 0", req_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_bytes();
    test_frame_limit();
    test_underrun();
    test_drain();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
